// File: rtl/lsu_ecc_scrub_ctl.sv
// DCCM single-bit ECC scrub controller: queues corrected bank data from dc3
// SEC events and rewrites it to the DCCM, sharing the write port with
// store-buffer drain. Also keeps saturating SEC/DED event counters.
module lsu_ecc_scrub_ctl #(
    parameter int unsigned DCCM_BITS = 16,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scrub_en,
    input  logic                 ecc_chk_valid_dc3,
    input  logic                 single_ecc_error_hi_dc3,
    input  logic                 single_ecc_error_lo_dc3,
    input  logic                 lsu_double_ecc_error_dc3,
    input  logic [DCCM_BITS-1:0] lsu_addr_dc3,
    input  logic [DCCM_BITS-1:0] end_addr_dc3,
    input  logic [63:0]          store_ecc_datafn_hi_dc3,
    input  logic [63:0]          store_ecc_datafn_lo_dc3,
    input  logic                 stbuf_wr_req,
    input  logic [DCCM_BITS-1:0] stbuf_wr_addr,
    input  logic [63:0]          stbuf_wr_data,
    output logic                 stbuf_wr_gnt,
    output logic                 dccm_wren,
    output logic [DCCM_BITS-1:0] dccm_wr_addr,
    output logic [63:0]          dccm_wr_data,
    output logic                 scrub_full,
    output logic                 scrub_busy,
    output logic                 scrub_drop,
    output logic [CNT_W-1:0]     ecc_sec_count,
    output logic [CNT_W-1:0]     ecc_ded_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic                 v_lo;
        logic [DCCM_BITS-1:0] addr_lo;
        logic [63:0]          data_lo;
        logic                 v_hi;
        logic [DCCM_BITS-1:0] addr_hi;
        logic [63:0]          data_hi;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t          state, next_state;
    entry_t          mem [DEPTH];
    entry_t          cap_entry, head, tail;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            fifo_empty, fifo_full;
    logic            sec_ev, ded_ev, cap, dup, push, pop;
    logic            unused_addr_lsbs;

    assign unused_addr_lsbs = ^{lsu_addr_dc3[2:0], end_addr_dc3[2:0]};

    // Capture qualification, entry formation and tail dedup
    assign sec_ev     = ecc_chk_valid_dc3 & scrub_en & ~lsu_double_ecc_error_dc3
                        & (single_ecc_error_hi_dc3 | single_ecc_error_lo_dc3);
    assign ded_ev     = ecc_chk_valid_dc3 & scrub_en & lsu_double_ecc_error_dc3;
    assign cap        = sec_ev;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign head       = mem[rd_ptr];
    assign tail       = mem[wr_ptr - AW'(1)];

    always_comb begin
        cap_entry         = '0;
        cap_entry.v_lo    = single_ecc_error_lo_dc3;
        cap_entry.addr_lo = {lsu_addr_dc3[DCCM_BITS-1:3], 3'b000};
        cap_entry.data_lo = store_ecc_datafn_lo_dc3;
        cap_entry.v_hi    = single_ecc_error_hi_dc3;
        cap_entry.addr_hi = {end_addr_dc3[DCCM_BITS-1:3], 3'b000};
        cap_entry.data_hi = store_ecc_datafn_hi_dc3;
    end

    assign dup = ~fifo_empty
                 & (cap_entry.v_lo == tail.v_lo) & (cap_entry.addr_lo == tail.addr_lo)
                 & (cap_entry.v_hi == tail.v_hi) & (cap_entry.addr_hi == tail.addr_hi);

    // A full FIFO still accepts when the head retires in the same cycle
    assign push       = cap & ~dup & (~fifo_full | pop);
    assign scrub_drop = cap & ~dup & fifo_full & ~pop;
    assign scrub_full = fifo_full;
    assign scrub_busy = ~fifo_empty | (state != IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Scrub sequencing and write-port arbitration; scrub always wins
    always_comb begin
        next_state   = state;
        pop          = 1'b0;
        stbuf_wr_gnt = 1'b0;
        dccm_wren    = 1'b0;
        dccm_wr_addr = '0;
        dccm_wr_data = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = head.v_lo ? WR_LO : WR_HI;
                end else if (stbuf_wr_req) begin
                    stbuf_wr_gnt = 1'b1;
                    dccm_wren    = 1'b1;
                    dccm_wr_addr = stbuf_wr_addr;
                    dccm_wr_data = stbuf_wr_data;
                end
            end
            WR_LO: begin
                dccm_wren    = 1'b1;
                dccm_wr_addr = head.addr_lo;
                dccm_wr_data = head.data_lo;
                if (head.v_hi) begin
                    next_state = WR_HI;
                end else begin
                    pop        = 1'b1;
                    next_state = IDLE;
                end
            end
            WR_HI: begin
                dccm_wren    = 1'b1;
                dccm_wr_addr = head.addr_hi;
                dccm_wr_data = head.data_hi;
                pop          = 1'b1;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO payload storage; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cap_entry;
    end

    // Saturating SEC/DED event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            ecc_sec_count <= '0;
            ecc_ded_count <= '0;
        end else begin
            if (sec_ev && (ecc_sec_count != '1)) ecc_sec_count <= ecc_sec_count + CNT_W'(1);
            if (ded_ev && (ecc_ded_count != '1)) ecc_ded_count <= ecc_ded_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/lsu_ecc_scrub_ctl.md
Name: lsu_ecc_scrub_ctl

Overview:
- Write-back controller for DCCM single-bit ECC corrections.
- On a dc3 load/store that reports a SEC error on the hi and/or lo bank, it captures the corrected 64-bit bank data (store_ecc_datafn_*) and the bank address into a small FIFO.
- It then sequences DCCM rewrites of those banks, arbitrating the DCCM write port against store-buffer drain.
- The parent LSU encodes ECC on dccm_wr_data with rvecc_encode_64. The block also keeps saturating SEC/DED event counters.

Parameters:
- DCCM_BITS, 16, DCCM byte-address width.
- DEPTH, 2, correction FIFO entries (power of 2, ≥2).
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- scrub_en  in  1  capture enable (~dec_tlu_core_ecc_disable)
- ecc_chk_valid_dc3  in  1  dc3 DCCM load/store with ECC checked (not flushed)
- single_ecc_error_hi_dc3  in  1  SEC on hi bank
- single_ecc_error_lo_dc3  in  1  SEC on lo bank
- lsu_double_ecc_error_dc3  in  1  DED on either bank
- lsu_addr_dc3  in  DCCM_BITS  start address
- end_addr_dc3  in  DCCM_BITS  end address
- store_ecc_datafn_hi_dc3  in  64  corrected/merged hi bank data
- store_ecc_datafn_lo_dc3  in  64  corrected/merged lo bank data
- stbuf_wr_req  in  1  store buffer drain request
- stbuf_wr_addr  in  DCCM_BITS  drain address
- stbuf_wr_data  in  64  drain data
- stbuf_wr_gnt  out  1  drain granted this cycle
- dccm_wren  out  1  DCCM write strobe
- dccm_wr_addr  out  DCCM_BITS  write address
- dccm_wr_data  out  64  write data
- scrub_full  out  1  FIFO full; pipeline must not issue DCCM loads/stores
- scrub_busy  out  1  FIFO non-empty or FSM not IDLE
- scrub_drop  out  1  one-cycle pulse: capture lost to overflow
- ecc_sec_count  out  CNT_W  saturating SEC event count
- ecc_ded_count  out  CNT_W  saturating DED event count

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied, FSM to IDLE, counters 0. All outputs 0, except dccm_wr_addr/data, which are 0 by mux.
- Capture:
  - cap = ecc_chk_valid_dc3 & scrub_en & (sec_hi|sec_lo) & ~ded.
  - An entry holds: v_lo=sec_lo, addr_lo={lsu_addr_dc3[DCCM_BITS-1:3],3'b0}, data_lo; v_hi=sec_hi, addr_hi={end_addr_dc3[DCCM_BITS-1:3],3'b0}, data_hi.
  - The entry is written at the posedge of the capture cycle. It is drainable the next cycle.
- Counting: sec count +1 per cycle with ecc_chk_valid_dc3 & scrub_en & (sec_hi|sec_lo) & ~ded. Hi and lo together count once. Ded count +1 per ecc_chk_valid_dc3 & scrub_en & ded. Both counters saturate at all-ones.
- Dedup: a capture whose (v,addr) pairs equal the FIFO tail entry's is not pushed, but is still counted.
- Overflow: on cap with FIFO full and no pop in the same cycle, the entry is dropped and scrub_drop=1 for that cycle. Cap with full FIFO and a same-cycle pop is accepted.
- scrub_full = (count==DEPTH), registered from the FIFO state.
- FSM states IDLE, WR_LO, WR_HI:
  - IDLE: if the FIFO is non-empty, go to WR_LO if head.v_lo, else WR_HI. No write in the transition cycle.
  - WR_LO: dccm_wren=1 with head lo addr/data. Next state is WR_HI if head.v_hi, else pop head and go IDLE.
  - WR_HI: dccm_wren=1 with head hi addr/data. Pop head and go IDLE.
  - Each bank write is exactly 1 cycle; the DCCM has no write backpressure.
- Arbitration:
  - stbuf_wr_gnt = stbuf_wr_req & (state==IDLE) & fifo_empty.
  - When granted, dccm_wren=1 with the stbuf addr/data in the same cycle.
  - Scrub always has priority. stbuf is never granted while a correction is pending.
- scrub_en deassert: new captures stop. Entries already queued still drain.
- Reset mid-write: the write in progress is abandoned and the FIFO is cleared.
- Invariant: at most one dccm_wren source per cycle.

Test Plan:
- Lo-only SEC: cap at cycle 0 with lsu_addr=0x0104, data_lo=0xDEADBEEF_01234567.
  - Cycle 1: IDLE→WR_LO.
  - Cycle 2: wren=1, addr=0x0100, data=0xDEADBEEF_01234567.
  - Cycle 3: IDLE, scrub_busy=0, sec_count=1.
- Dual-bank SEC with lsu_addr=0x0106, end=0x010D: writes 0x0100 (lo) then 0x0108 (hi) on consecutive cycles. Single pop, sec_count=1.
- stbuf_wr_req held during a scrub: gnt=0 until the FIFO is empty and IDLE. Gnt=1 on the cycle after the last scrub write, and dccm_wr_addr=stbuf_wr_addr.
- DEPTH=2 with three back-to-back distinct caps, no drain possible yet: scrub_full=1 after the 2nd, scrub_drop pulses on the 3rd, sec_count=3.
- DED with SEC asserted: no push, ded_count=1, sec_count unchanged. Preload ded_count=0xFFFF (CNT_W=16) → stays 0xFFFF.
- rst asserted during WR_LO with 2 entries queued: next cycle wren=0, busy=0, counters 0. An identical repeat capture after reset drains normally.
